// File: rtl/stream_pkg.sv
// Shared types and helpers for the store-and-forward packet buffer.
package stream_pkg;

  // Default field widths of one stored beat.
  localparam int T_DATA_WIDTH_DEF = 4;
  localparam int T_QOS__WIDTH_DEF = 2;
  localparam int T_ID___WIDTH_DEF = 2;
  localparam int DEPTH_DEF        = 8;

  // One stored beat, laid out MSB first as {data, qos, id, last}.
  // The top module packs its words in exactly this order, so a RAM word
  // of the default configuration can be cast straight to beat_t.
  typedef struct packed {
    logic [T_DATA_WIDTH_DEF-1:0] data;
    logic [T_QOS__WIDTH_DEF-1:0] qos;
    logic [T_ID___WIDTH_DEF-1:0] id;
    logic                        last;
  } beat_t;

  // STORE: forward only complete packets. CUT: forward whatever is held,
  // used when a single packet is larger than the whole buffer.
  typedef enum logic {
    STORE = 1'b0,
    CUT   = 1'b1
  } fifo_state_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_WIDTH_DEF = cnt_width(DEPTH_DEF);

  // Width of one packed beat for arbitrary field widths.
  function automatic int beat_width(input int dw, input int qw, input int iw);
    return dw + qw + iw + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read.
// The asynchronous read lets the head beat fall through to the outputs
// in the same cycle the read pointer moves.
module stream_fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write port: store one beat on an accepted push. Contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_pkt_fifo.sv
// Store-and-forward packet buffer behind the QoS stream arbiter.
// Beats are held until the packet's last beat is stored, then the packet
// is forwarded at one beat per clock. A packet that fills the buffer with
// no complete packet inside switches the block to cut-through so it can
// never deadlock; cut-through ends when that packet's last beat leaves.
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high on that side. A source holding valid high without ready keeps
// its payload stable; valid never depends on ready, and s_ready_out is
// low whenever the buffer is full, even if a pop happens that same cycle.
module stream_pkt_fifo
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int T_QOS__WIDTH = T_QOS__WIDTH_DEF,
  parameter int T_ID___WIDTH = T_ID___WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_in,
  input  logic [T_QOS__WIDTH-1:0] s_qos_in,
  input  logic [T_ID___WIDTH-1:0] s_id_in,
  input  logic                    s_last_in,
  input  logic                    s_valid_in,
  output logic                    s_ready_out,
  output logic [T_DATA_WIDTH-1:0] m_data_out,
  output logic [T_QOS__WIDTH-1:0] m_qos_out,
  output logic [T_ID___WIDTH-1:0] m_id_out,
  output logic                    m_last_out,
  output logic                    m_valid_out,
  input  logic                    m_ready_in,
  output logic [$clog2(DEPTH):0]  pkt_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int W  = beat_width(T_DATA_WIDTH, T_QOS__WIDTH, T_ID___WIDTH);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = '0;

  // Registered state
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pkt_cnt;
  fifo_state_e   r_state;

  // Datapath wires
  logic [W-1:0] w_wdata;
  logic [W-1:0] w_rdata;
  logic         w_push;
  logic         w_pop;
  logic         w_push_last;
  logic         w_pop_last;
  logic         w_full;
  logic         w_head_last;

  assign w_full      = (r_count == FULL_CNT);
  assign w_wdata     = {s_data_in, s_qos_in, s_id_in, s_last_in};
  assign w_head_last = w_rdata[0];

  // Head beat falls through straight from the RAM word at the read pointer.
  assign m_data_out = w_rdata[W-1 -: T_DATA_WIDTH];
  assign m_qos_out  = w_rdata[T_ID___WIDTH+T_QOS__WIDTH -: T_QOS__WIDTH];
  assign m_id_out   = w_rdata[T_ID___WIDTH -: T_ID___WIDTH];
  assign m_last_out = w_head_last;

  // No pop bypass when full: ready depends on stored count only.
  assign s_ready_out = !w_full;

  // In STORE only complete packets are presentable; in CUT any held beat is.
  assign m_valid_out = (r_state == CUT) ? (r_count != ZERO_CNT)
                                        : (r_pkt_cnt != ZERO_CNT);

  assign w_push      = s_valid_in && s_ready_out;
  assign w_pop       = m_valid_out && m_ready_in;
  assign w_push_last = w_push && s_last_in;
  assign w_pop_last  = w_pop && w_head_last;

  assign pkt_count_out = r_pkt_cnt;

  stream_fifo_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers advance on their own handshake and wrap at DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Beat occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Complete-packet count: a stored last beat adds one, a popped one removes one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_push_last, w_pop_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + ONE_CNT;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - ONE_CNT;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Forwarding mode: enter CUT when a packet fills the buffer without ending,
  // leave it once the last beat of that packet has been popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STORE;
    end else begin
      case (r_state)
        STORE: if (w_full && (r_pkt_cnt == ZERO_CNT)) r_state <= CUT;
        CUT:   if (w_pop_last) r_state <= STORE;
        default: r_state <= STORE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Bench for the store-and-forward packet buffer: directed scenarios plus a
// randomized run, all checked against a queue-based packet model.
module tb_stream_pkt_fifo;

  localparam int DW    = 4;
  localparam int QW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int W     = DW + QW + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data_in  = '0;
  logic [QW-1:0] s_qos_in   = '0;
  logic [IW-1:0] s_id_in    = '0;
  logic          s_last_in  = 1'b0;
  logic          s_valid_in = 1'b0;
  logic          s_ready_out;
  logic [DW-1:0] m_data_out;
  logic [QW-1:0] m_qos_out;
  logic [IW-1:0] m_id_out;
  logic          m_last_out;
  logic          m_valid_out;
  logic          m_ready_in = 1'b0;
  logic [3:0]    pkt_count_out;

  stream_pkt_fifo #(
    .T_DATA_WIDTH (DW),
    .T_QOS__WIDTH (QW),
    .T_ID___WIDTH (IW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data_in     (s_data_in),
    .s_qos_in      (s_qos_in),
    .s_id_in       (s_id_in),
    .s_last_in     (s_last_in),
    .s_valid_in    (s_valid_in),
    .s_ready_out   (s_ready_out),
    .m_data_out    (m_data_out),
    .m_qos_out     (m_qos_out),
    .m_id_out      (m_id_out),
    .m_last_out    (m_last_out),
    .m_valid_out   (m_valid_out),
    .m_ready_in    (m_ready_in),
    .pkt_count_out (pkt_count_out)
  );

  // ---------------- reference model ----------------
  // Held beats as {data, qos, id, last}, number of complete packets held,
  // and whether an oversized packet is being cut through.
  logic [W-1:0] exp_q[$];
  int           m_pkts = 0;
  bit           m_cut = 1'b0;
  bit           last_push = 1'b0;
  int           total = 0;
  int           bad = 0;

  function automatic logic mdl_valid();
    return m_cut ? (exp_q.size() != 0) : (m_pkts != 0);
  endfunction

  function automatic logic mdl_ready();
    return exp_q.size() != DEPTH;
  endfunction

  task automatic mdl_clear();
    exp_q.delete();
    m_pkts = 0;
    m_cut = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and apply the same transfer to the model.
  task automatic tick();
    logic         push;
    logic         pop;
    logic         go_cut;
    logic [W-1:0] head;
    push   = s_valid_in && mdl_ready();
    pop    = m_ready_in && mdl_valid();
    go_cut = !m_cut && (exp_q.size() == DEPTH) && (m_pkts == 0);
    @(posedge clk);
    if (pop) begin
      head = exp_q.pop_front();
      if (head[0]) begin
        m_pkts--;
        m_cut = 1'b0;
      end
    end
    if (push) begin
      exp_q.push_back({s_data_in, s_qos_in, s_id_in, s_last_in});
      if (s_last_in) m_pkts++;
    end
    if (go_cut) m_cut = 1'b1;
    last_push = push;
    #1;
  endtask

  task automatic drive_beat(input logic [W-1:0] b);
    {s_data_in, s_qos_in, s_id_in, s_last_in} = b;
    s_valid_in = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (s_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", s_ready_out); end
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", m_valid_out); end
    total++; if (pkt_count_out !== 4'd0) begin bad++; $display("FAIL reset_pkt got=%0d want=0", pkt_count_out); end
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
  endtask

  task automatic test_single_beat();
    m_ready_in = 1'b0;
    drive_beat({4'hA, 2'd1, 2'd2, 1'b1});
    tick();
    s_valid_in = 1'b0;
    total++; if (m_valid_out !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", m_valid_out); end
    total++; if (m_data_out !== 4'hA) begin bad++; $display("FAIL single_data got=%h want=a", m_data_out); end
    total++; if (m_qos_out !== 2'd1) begin bad++; $display("FAIL single_qos got=%0d want=1", m_qos_out); end
    total++; if (m_id_out !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", m_id_out); end
    total++; if (pkt_count_out !== 4'd1) begin bad++; $display("FAIL single_pkt got=%0d want=1", pkt_count_out); end
    m_ready_in = 1'b1;
    tick();
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL single_empty got=%0b want=0", m_valid_out); end
    total++; if (pkt_count_out !== 4'd0) begin bad++; $display("FAIL single_pkt0 got=%0d want=0", pkt_count_out); end
  endtask

  task automatic test_store_hold();
    logic [DW-1:0] want [3];
    want[0] = 4'hC; want[1] = 4'hD; want[2] = 4'hB;
    m_ready_in = 1'b1;
    drive_beat({4'hC, 2'd0, 2'd1, 1'b0});
    tick();
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL hold_v1 got=%0b want=0", m_valid_out); end
    drive_beat({4'hD, 2'd2, 2'd1, 1'b0});
    tick();
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL hold_v2 got=%0b want=0", m_valid_out); end
    drive_beat({4'hB, 2'd3, 2'd1, 1'b1});
    tick();
    s_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (m_valid_out !== 1'b1) begin bad++; $display("FAIL hold_out_valid beat=%0d got=%0b want=1", i, m_valid_out); end
      total++; if (m_data_out !== want[i]) begin bad++; $display("FAIL hold_out_data beat=%0d got=%h want=%h", i, m_data_out, want[i]); end
      total++; if (m_last_out !== (i == 2)) begin bad++; $display("FAIL hold_out_last beat=%0d got=%0b", i, m_last_out); end
      tick();
    end
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL hold_drained got=%0b want=0", m_valid_out); end
  endtask

  task automatic test_full();
    m_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_beat({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), (i % 4) == 3});
      tick();
    end
    total++; if (s_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", s_ready_out); end
    total++; if (pkt_count_out !== 4'd2) begin bad++; $display("FAIL full_pkt got=%0d want=2", pkt_count_out); end
    // Extra beat offered while a pop happens: must not be taken this cycle.
    drive_beat({4'h5, 2'd1, 2'd0, 1'b1});
    m_ready_in = 1'b1;
    total++; if (s_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready_pop got=%0b want=0", s_ready_out); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      total++; if (m_valid_out !== 1'b1) begin bad++; $display("FAIL full_bubble beat=%0d got=%0b want=1", i, m_valid_out); end
      total++; if ({m_data_out, m_qos_out, m_id_out, m_last_out} !== exp_q[0]) begin bad++; $display("FAIL full_order beat=%0d got=%h want=%h", i, {m_data_out, m_qos_out, m_id_out, m_last_out}, exp_q[0]); end
      tick();
      if (last_push) s_valid_in = 1'b0;
    end
    total++; if (m_valid_out !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL full_drained got=%0b want=0", m_valid_out); end
  endtask

  task automatic test_oversize();
    logic [W-1:0] beats [12];
    int idx = 0;
    int outn = 0;
    for (int i = 0; i < 12; i++) beats[i] = {4'(i + 3), 2'(i), 2'(i + 1), i == 11};
    m_ready_in = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 12) drive_beat(beats[idx]);
      tick();
      if (last_push) idx++;
    end
    total++; if (s_ready_out !== 1'b0) begin bad++; $display("FAIL cut_ready got=%0b want=0", s_ready_out); end
    total++; if (m_valid_out !== 1'b1) begin bad++; $display("FAIL cut_valid got=%0b want=1", m_valid_out); end
    total++; if (pkt_count_out !== 4'd0) begin bad++; $display("FAIL cut_pkt got=%0d want=0", pkt_count_out); end
    m_ready_in = 1'b1;
    for (int c = 0; c < 40 && outn < 12; c++) begin
      if (idx < 12) drive_beat(beats[idx]); else s_valid_in = 1'b0;
      if (m_valid_out === 1'b1) begin
        total++; if ({m_data_out, m_qos_out, m_id_out, m_last_out} !== beats[outn]) begin bad++; $display("FAIL cut_order beat=%0d got=%h want=%h", outn, {m_data_out, m_qos_out, m_id_out, m_last_out}, beats[outn]); end
        outn++;
      end
      tick();
      if (last_push) idx++;
    end
    s_valid_in = 1'b0;
    total++; if (outn != 12) begin bad++; $display("FAIL cut_count got=%0d want=12", outn); end
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL cut_empty got=%0b want=0", m_valid_out); end
    // Back in STORE: an unfinished packet must be held again.
    drive_beat({4'h7, 2'd0, 2'd0, 1'b0});
    tick();
    s_valid_in = 1'b0;
    tick();
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL cut_back_store got=%0b want=0", m_valid_out); end
    drive_beat({4'h8, 2'd0, 2'd0, 1'b1});
    tick();
    s_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({m_valid_out, m_data_out} !== {1'b1, 4'(7 + i)}) begin bad++; $display("FAIL cut_after_pkt beat=%0d got=%b_%h", i, m_valid_out, m_data_out); end
      tick();
    end
  endtask

  task automatic test_simul_last();
    m_ready_in = 1'b0;
    drive_beat({4'h1, 2'd0, 2'd0, 1'b1});
    tick();
    total++; if (pkt_count_out !== 4'd1) begin bad++; $display("FAIL simul_pre got=%0d want=1", pkt_count_out); end
    drive_beat({4'h2, 2'd1, 2'd1, 1'b1});
    m_ready_in = 1'b1;
    tick();
    s_valid_in = 1'b0;
    total++; if (pkt_count_out !== 4'd1) begin bad++; $display("FAIL simul_pkt got=%0d want=1", pkt_count_out); end
    total++; if ({m_valid_out, m_data_out} !== {1'b1, 4'h2}) begin bad++; $display("FAIL simul_head got=%b_%h want=1_2", m_valid_out, m_data_out); end
    tick();
    total++; if ({m_valid_out, pkt_count_out} !== 5'b0_0000) begin bad++; $display("FAIL simul_drain got=%b_%0d want=0_0", m_valid_out, pkt_count_out); end
  endtask

  task automatic test_reset_mid();
    m_ready_in = 1'b1;
    drive_beat({4'h3, 2'd2, 2'd3, 1'b0});
    tick();
    drive_beat({4'h4, 2'd2, 2'd3, 1'b0});
    tick();
    s_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (s_ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", s_ready_out); end
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", m_valid_out); end
    total++; if (pkt_count_out !== 4'd0) begin bad++; $display("FAIL mid_pkt got=%0d want=0", pkt_count_out); end
    #1;
    rst = 1'b0;
    mdl_clear();
    m_ready_in = 1'b0;
    drive_beat({4'h9, 2'd3, 2'd1, 1'b1});
    tick();
    s_valid_in = 1'b0;
    total++; if ({m_valid_out, m_data_out, m_qos_out, m_id_out, m_last_out} !== {1'b1, 4'h9, 2'd3, 2'd1, 1'b1}) begin bad++; $display("FAIL mid_after got=%b_%h_%0d_%0d_%b", m_valid_out, m_data_out, m_qos_out, m_id_out, m_last_out); end
    m_ready_in = 1'b1;
    tick();
    total++; if (m_valid_out !== 1'b0) begin bad++; $display("FAIL mid_drain got=%0b want=0", m_valid_out); end
  endtask

  task automatic test_random();
    last_push = 1'b0;
    s_valid_in = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!s_valid_in || last_push) begin
        s_valid_in = ($urandom_range(0, 3) != 0);
        s_data_in  = 4'($urandom_range(0, 15));
        s_qos_in   = 2'($urandom_range(0, 3));
        s_id_in    = 2'($urandom_range(0, 3));
        s_last_in  = (c < 400) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) == 0);
      end
      m_ready_in = (c < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      total++; if (s_ready_out !== mdl_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", c, s_ready_out, mdl_ready()); end
      total++; if (m_valid_out !== mdl_valid()) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, m_valid_out, mdl_valid()); end
      total++; if (pkt_count_out !== 4'(m_pkts)) begin bad++; $display("FAIL rnd_pkt cyc=%0d got=%0d want=%0d", c, pkt_count_out, m_pkts); end
      if (mdl_valid()) begin
        total++; if ({m_data_out, m_qos_out, m_id_out, m_last_out} !== exp_q[0]) begin bad++; $display("FAIL rnd_beat cyc=%0d got=%h want=%h", c, {m_data_out, m_qos_out, m_id_out, m_last_out}, exp_q[0]); end
      end
      tick();
    end
    s_valid_in = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_beat();
    test_store_hold();
    test_full();
    test_oversize();
    test_simul_last();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "run exceeded time bound");
  end

endmodule
